// File: rtl/store_ctrl.sv
// Segment store controller: moves the four L1 words to/from an external segment memory.
// Optional per-access ack timeout is built when STORE_TIMEOUT_EN is defined.
module store_ctrl #(
    parameter int DW     = 8,
    parameter int SEG_W  = 8,
    parameter int TO_CYC = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              store_write,
    input  logic              store_read,
    input  logic              store_call,
    input  logic [SEG_W-1:0]  SA,
    input  logic [SEG_W-1:0]  SB,
    input  logic [SEG_W-1:0]  SC,
    output logic              store_busy,
    output logic              L1_write,
    output logic              L1_read,
    output logic [1:0]        L1_ADDR,
    inout  wire  [DW-1:0]     L12loader,
    output logic [SEG_W+1:0]  mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic              mem_ack,
    output logic              store_err
);

    typedef enum logic [2:0] {IDLE, L1X, MWR, MRD, L1W, DONE} state_t;

    state_t           state, state_nx;
    logic [1:0]       idx, idx_nx;
    logic [SEG_W-1:0] seg, seg_nx;
    logic [DW-1:0]    data_buf, data_buf_nx;
    logic             accept;
    logic             timeout;
    logic             any_req;

    assign any_req = store_write | store_read | store_call;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= IDLE;
            idx      <= 2'd0;
            seg      <= '0;
            data_buf <= '0;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            seg      <= seg_nx;
            data_buf <= data_buf_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        seg_nx      = seg;
        data_buf_nx = data_buf;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                if (store_call) begin
                    accept   = 1'b1;
                    seg_nx   = SC;
                    idx_nx   = 2'd0;
                    state_nx = L1X;
                end else if (store_write) begin
                    accept   = 1'b1;
                    seg_nx   = SA;
                    idx_nx   = 2'd0;
                    state_nx = L1X;
                end else if (store_read) begin
                    accept   = 1'b1;
                    seg_nx   = SB;
                    idx_nx   = 2'd0;
                    state_nx = MRD;
                end
            end
            L1X: begin
                data_buf_nx = L12loader;
                state_nx    = MWR;
            end
            MWR: begin
                if (mem_ack) begin
                    if (idx == 2'd3) begin
                        state_nx = DONE;
                    end else begin
                        idx_nx   = idx + 2'd1;
                        state_nx = L1X;
                    end
                end else if (timeout) begin
                    state_nx = DONE;
                end
            end
            MRD: begin
                if (mem_ack) begin
                    data_buf_nx = mem_rdata;
                    state_nx    = L1W;
                end else if (timeout) begin
                    state_nx = DONE;
                end
            end
            L1W: begin
                if (idx == 2'd3) begin
                    state_nx = DONE;
                end else begin
                    idx_nx   = idx + 2'd1;
                    state_nx = MRD;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

`ifdef STORE_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYC + 1);

    logic [CW-1:0] to_cnt;
    logic          err_q;

    // Counts consecutive ack-less cycles of the current access; cleared outside MWR/MRD.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            to_cnt <= '0;
        end else if ((state == MWR || state == MRD) && !mem_ack) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end

    assign timeout = (state == MWR || state == MRD) && !mem_ack &&
                     (to_cnt == CW'(TO_CYC - 1));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign store_err = err_q;
`else
    logic unused_to;

    assign unused_to = (TO_CYC == 0) | accept;
    assign timeout   = 1'b0;
    assign store_err = 1'b0;
`endif

    assign store_busy = ((state != IDLE) && (state != DONE)) || ((state == IDLE) && any_req);
    assign L1_write   = (state == L1X);
    assign L1_read    = (state == L1W);
    assign mem_we     = (state == MWR);
    assign mem_re     = (state == MRD);
    assign L1_ADDR    = (L1_write || L1_read) ? idx : 2'd0;
    assign mem_addr   = (mem_we || mem_re) ? {seg, idx} : '0;
    assign mem_wdata  = mem_we ? data_buf : '0;
    assign L12loader  = L1_read ? data_buf : {DW{1'bz}};

endmodule

// File: tb/tb_store_ctrl.sv
// Directed bench for store_ctrl: behavioural L1 window and variable-latency memory around the DUT.
// Define STORE_TIMEOUT_EN for both files to include the timeout scenario.
module tb_store_ctrl;

    localparam int DW    = 8;
    localparam int SEG_W = 8;
    localparam int W     = SEG_W + 2 + DW;

    logic             CLK;
    logic             RESET;
    logic             store_write, store_read, store_call;
    logic [SEG_W-1:0] SA, SB, SC;
    logic             store_busy;
    logic             L1_write, L1_read;
    logic [1:0]       L1_ADDR;
    wire  [DW-1:0]    L12loader;
    logic [SEG_W+1:0] mem_addr;
    logic [DW-1:0]    mem_wdata, mem_rdata;
    logic             mem_we, mem_re, mem_ack;
    logic             store_err;

    store_ctrl #(.DW(DW), .SEG_W(SEG_W), .TO_CYC(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .store_write(store_write), .store_read(store_read), .store_call(store_call),
        .SA(SA), .SB(SB), .SC(SC),
        .store_busy(store_busy),
        .L1_write(L1_write), .L1_read(L1_read), .L1_ADDR(L1_ADDR),
        .L12loader(L12loader),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_ack(mem_ack),
        .store_err(store_err)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // L1 window model: core drives the word while L1_write, latches it while L1_read.
    logic [DW-1:0] l1 [4];
    assign L12loader = L1_write ? l1[L1_ADDR] : {DW{1'bz}};

    // memory model and scoreboards
    logic [DW-1:0] mem [1024];
    int            wait_cyc = 0;
    int            wcnt     = 0;
    logic          no_ack   = 1'b0;
    int            re_cnt   = 0;
    logic [W-1:0]  exp_q[$];
    logic [9:0]    exp_rd[$];

    always @(negedge CLK) begin
        check("excl_mem", {31'd0, mem_we & mem_re}, 32'd0);
        check("excl_l1", {31'd0, L1_write & L1_read}, 32'd0);
        if (mem_re) re_cnt++;
        if ((mem_we || mem_re) && !no_ack) begin
            if (wcnt == wait_cyc) begin
                mem_ack = 1'b1;
                wcnt    = 0;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    if (exp_q.size() == 0) check("wr_unexp", exp_q.size(), 1);
                    else check("wr", {14'd0, mem_addr, mem_wdata}, {14'd0, exp_q.pop_front()});
                end else begin
                    mem_rdata = mem[mem_addr];
                end
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end
        if (L1_read) begin
            l1[L1_ADDR] = L12loader;
            if (exp_rd.size() == 0) check("rd_unexp", exp_rd.size(), 1);
            else check("rd", {22'd0, L1_ADDR, L12loader}, {22'd0, exp_rd.pop_front()});
        end
    end

    // driver: issue requests, count busy cycles up to and including the request cycle
    task automatic run_req(input string tag, input logic w, input logic r, input logic c,
                           input logic hold, input int exp_busy);
        int cnt;
        @(negedge CLK);
        store_write = w;
        store_read  = r;
        store_call  = c;
        cnt = 0;
        #1;
        if (store_busy) cnt++;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            #1;
            if (!hold) begin
                store_write = 1'b0;
                store_read  = 1'b0;
                store_call  = 1'b0;
            end
            if (!store_busy) break;
            cnt++;
        end
        check({tag, "_busy"}, cnt, exp_busy);
        store_write = 1'b0;
        store_read  = 1'b0;
        store_call  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) @(negedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b0;
        store_write = 1'b0; store_read = 1'b0; store_call = 1'b0;
        SA = '0; SB = '0; SC = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        l1[0] = 8'hA0; l1[1] = 8'hA1; l1[2] = 8'hA2; l1[3] = 8'hA3;

        // reset values
        #12;
        check("rst_busy", store_busy, 0);
        check("rst_l1w", L1_write, 0);
        check("rst_l1r", L1_read, 0);
        check("rst_we", mem_we, 0);
        check("rst_re", mem_re, 0);
        check("rst_l1addr", L1_ADDR, 0);
        check("rst_maddr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_err", store_err, 0);
        check("rst_bus_z", {31'd0, L12loader === 8'hzz}, 1);
        @(negedge CLK);
        RESET = 1'b1;
        idle_cycles(2);

        // SAVE SA=0x12, immediate ack
        SA = 8'h12; wait_cyc = 0;
        for (int i = 0; i < 4; i++) exp_q.push_back({10'h048 + 10'(i), 8'hA0 + 8'(i)});
        run_req("save", 1'b1, 1'b0, 1'b0, 1'b0, 9);
        idle_cycles(2);
        check("save_left", exp_q.size(), 0);

        // LOAD SB=0x05, two wait cycles per access
        SB = 8'h05; wait_cyc = 2;
        for (int i = 0; i < 4; i++) begin
            mem[10'h014 + i] = 8'(i + 1);
            exp_rd.push_back({2'(i), 8'(i + 1)});
        end
        run_req("load", 1'b0, 1'b1, 1'b0, 1'b0, 17);
        idle_cycles(2);
        check("load_left", exp_rd.size(), 0);
        check("load_l1_3", l1[3], 8'h04);

        // all three requests: only CALL to SC=0x07 executes
        SA = 8'h20; SB = 8'h05; SC = 8'h07; wait_cyc = 1;
        for (int i = 0; i < 4; i++) exp_q.push_back({10'h01C + 10'(i), 8'(i + 1)});
        run_req("prio", 1'b1, 1'b1, 1'b1, 1'b0, 13);
        idle_cycles(2);
        check("prio_left", exp_q.size(), 0);
        check("prio_sa_mem", mem[10'h080], 8'h00);

        // SAVE held through DONE: one transfer only
        SA = 8'h30; wait_cyc = 0;
        for (int i = 0; i < 4; i++) exp_q.push_back({10'h0C0 + 10'(i), 8'(i + 1)});
        run_req("hold", 1'b1, 1'b0, 1'b0, 1'b1, 9);
        idle_cycles(4);
        check("hold_left", exp_q.size(), 0);
        check("hold_idle_busy", store_busy, 0);

        // reset during the second MWR of a SAVE
        SA = 8'h03; wait_cyc = 3;
        exp_q.push_back({10'h00C, 8'h01});
        @(negedge CLK);
        store_write = 1'b1;
        @(negedge CLK);
        store_write = 1'b0;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (mem_we && mem_addr == 10'h00D) break;
            @(negedge CLK);
        end
        check("mid_reach", {31'd0, mem_we}, 1);
        RESET = 1'b0;
        #1;
        check("mid_busy", store_busy, 0);
        check("mid_we", mem_we, 0);
        check("mid_maddr", mem_addr, 0);
        check("mid_wdata", mem_wdata, 0);
        check("mid_l1addr", L1_ADDR, 0);
        check("mid_bus_z", {31'd0, L12loader === 8'hzz}, 1);
        idle_cycles(2);
        RESET = 1'b1;
        idle_cycles(4);
        check("mid_post_busy", store_busy, 0);
        check("mid_left", exp_q.size(), 0);
        check("mid_mem_kept", mem[10'h00C], 8'h01);

`ifdef STORE_TIMEOUT_EN
        // LOAD with no ack: strobe for 4 cycles, then error and DONE
        SB = 8'h09; no_ack = 1'b1; re_cnt = 0;
        run_req("to", 1'b0, 1'b1, 1'b0, 1'b0, 5);
        check("to_err", store_err, 1);
        idle_cycles(2);
        check("to_re_cnt", re_cnt, 4);
        check("to_l1_0", l1[0], 8'h01);
        no_ack = 1'b0;
        SA = 8'h01; wait_cyc = 0;
        for (int i = 0; i < 4; i++) exp_q.push_back({10'h004 + 10'(i), 8'(i + 1)});
        run_req("to_save", 1'b1, 1'b0, 1'b0, 1'b0, 9);
        check("to_err_clr", store_err, 0);
        idle_cycles(2);
        check("to_save_left", exp_q.size(), 0);
`else
        check("err_tied", store_err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
